mem_port_arbiter: RTL and testbench

// - Shares one unified single-port synchronous memory between the pipeline's instruction-fetch port (IF) and data-memory port (DM, MEM stage).
// - Grants at most one access per cycle; DM has priority, with a starvation guard for IF.
// - Tracks in-flight reads so each read datum returns to its requester.
// - Produces stall_if / stall_dm for the hazard logic: stalled stage holds its PC/pipe register.

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/rd_tag_pipe.sv | 37 +++
 rtl/mem_port_arbiter.sv | 101 ++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter: read-owner tags and latency bound.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/rd_tag_pipe.sv
// Owner-tag shift register: a tag entering at stage 0 leaves the tail RD_LAT cycles later,
// lining up with the read datum the memory returns for that access.
module rd_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  owner_e in_tag,
    output owner_e out_tag
);

    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
        owner_e tag_reg;
        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (!reset) begin
                    tag_reg <= OWN_NONE;
                end else begin
                    tag_reg <= in_tag;
                end
            end
        end else begin : g_body
            always_ff @(posedge clk) begin
                if (!reset) begin
                    tag_reg <= OWN_NONE;
                end else begin
                    tag_reg <= g_stage[gi-1].tag_reg;
                end
            end
        end
    end

    assign out_tag = g_stage[RD_LAT-1].tag_reg;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and DM onto one single-port memory: DM wins ties unless IF has been
// denied STARVE_MAX cycles in a row; read data is routed back by an owner-tag pipe.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [2:0]        dm_funct3,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              stall_if,
    output logic              stall_dm,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [3:0] starve_cnt_reg, starve_cnt_next;
    logic       force_if;
    logic       if_win, dm_win;
    owner_e     in_tag, out_tag;

    assign force_if = (starve_cnt_reg == 4'(STARVE_MAX));

    always_comb begin
        if_win = if_req & (~dm_req | force_if);
        dm_win = dm_req & ~if_win;
    end

    // Handshake outputs are forced low while reset is held.
    assign if_gnt   = reset & if_win;
    assign dm_gnt   = reset & dm_win;
    assign stall_if = reset & if_req & ~if_win;
    assign stall_dm = reset & dm_req & ~dm_win;

    assign mem_en     = if_gnt | dm_gnt;
    assign mem_we     = dm_gnt & dm_we;
    assign mem_addr   = dm_win ? dm_addr : if_addr;
    assign mem_wdata  = dm_wdata;
    // Instruction fetches are always full-word accesses.
    assign mem_funct3 = dm_win ? dm_funct3 : 3'b010;

    always_comb begin
        in_tag = OWN_NONE;
        if (if_gnt) begin
            in_tag = OWN_IF;
        end else if (dm_gnt && !dm_we) begin
            in_tag = OWN_DM;
        end
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!if_req || if_win) begin
            starve_cnt_next = 4'd0;
        end else if (starve_cnt_reg != 4'(STARVE_MAX)) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt_reg <= 4'd0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .in_tag  (in_tag),
        .out_tag (out_tag)
    );

    assign if_rvalid = reset & (out_tag == OWN_IF);
    assign dm_rvalid = reset & (out_tag == OWN_DM);
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives three arbiters (RD_LAT 1..3) with shared directed stimulus; a cycle-level model
// of the arbitration and response rules is compared against every instance each cycle.
module tb_mem_port_arbiter;

    localparam int SM = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mem_init;
    logic        if_req, dm_req, dm_we;
    logic [8:0]  if_addr, dm_addr;
    logic [31:0] dm_wdata;
    logic [2:0]  dm_funct3;

    logic [3:1]  if_gnt_a, if_rvalid_a, dm_gnt_a, dm_rvalid_a;
    logic [3:1]  stall_if_a, stall_dm_a, mem_en_a, mem_we_a;
    logic [31:0] if_rdata_a [1:3];
    logic [31:0] dm_rdata_a [1:3];
    logic [31:0] mem_wdata_a [1:3];
    logic [31:0] mem_rdata_a [1:3];
    logic [8:0]  mem_addr_a [1:3];
    logic [2:0]  mem_funct3_a [1:3];

    int checks = 0;
    int failures = 0;

    for (genvar gi = 1; gi <= 3; gi++) begin : g_lat
        logic [31:0] mem  [0:127];
        logic [31:0] pipe [0:3];

        // Synchronous memory with gi cycles of read latency.
        always @(posedge clk) begin
            if (mem_init) begin
                for (int i = 0; i < 128; i++) mem[i] <= 32'hA500_0000 | i;
            end else if (mem_en_a[gi] && mem_we_a[gi]) begin
                mem[mem_addr_a[gi][8:2]] <= mem_wdata_a[gi];
            end
            pipe[0] <= (mem_en_a[gi] && !mem_we_a[gi]) ? mem[mem_addr_a[gi][8:2]] : 32'h0;
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata_a[gi] = pipe[gi-1];

        mem_port_arbiter #(
            .ADDR_W(9), .DATA_W(32), .RD_LAT(gi), .STARVE_MAX(SM)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .if_req     (if_req),
            .if_addr    (if_addr),
            .if_gnt     (if_gnt_a[gi]),
            .if_rvalid  (if_rvalid_a[gi]),
            .if_rdata   (if_rdata_a[gi]),
            .dm_req     (dm_req),
            .dm_we      (dm_we),
            .dm_addr    (dm_addr),
            .dm_wdata   (dm_wdata),
            .dm_funct3  (dm_funct3),
            .dm_gnt     (dm_gnt_a[gi]),
            .dm_rvalid  (dm_rvalid_a[gi]),
            .dm_rdata   (dm_rdata_a[gi]),
            .stall_if   (stall_if_a[gi]),
            .stall_dm   (stall_dm_a[gi]),
            .mem_en     (mem_en_a[gi]),
            .mem_we     (mem_we_a[gi]),
            .mem_addr   (mem_addr_a[gi]),
            .mem_wdata  (mem_wdata_a[gi]),
            .mem_funct3 (mem_funct3_a[gi]),
            .mem_rdata  (mem_rdata_a[gi])
        );
    end

    task automatic chk(input string name, input int lat, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s lat=%0d t=%0t actual=%h required=%h", name, lat, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    int          cyc = 0;
    int          own_h [0:1023];
    logic [31:0] dat_h [0:1023];
    logic        rst_h [0:1023];
    logic [31:0] ref_mem [0:127];

    initial begin
        int   deny;
        logic exp_if, exp_dm;
        int   e_own;
        deny = 0;
        for (int i = 0; i < 128; i++) ref_mem[i] = 32'hA500_0000 | i;
        forever begin
            @(negedge clk);
            exp_if = reset & if_req & (!dm_req | (deny == SM));
            exp_dm = reset & dm_req & !exp_if;
            rst_h[cyc] = reset;
            own_h[cyc] = exp_if ? 1 : ((exp_dm && !dm_we) ? 2 : 0);
            dat_h[cyc] = exp_if ? ref_mem[if_addr[8:2]] : ref_mem[dm_addr[8:2]];
            if (exp_dm && dm_we) ref_mem[dm_addr[8:2]] = dm_wdata;
            if (exp_if || exp_dm)
                $display("txn cyc=%0d port=%s we=%0d addr=%h", cyc, exp_if ? "IF" : "DM",
                         exp_dm & dm_we, exp_if ? if_addr : dm_addr);
            for (int l = 1; l <= 3; l++) begin
                chk("if_gnt", l, 32'(if_gnt_a[l]), 32'(exp_if));
                chk("dm_gnt", l, 32'(dm_gnt_a[l]), 32'(exp_dm));
                chk("stall_if", l, 32'(stall_if_a[l]), 32'(reset & if_req & !exp_if));
                chk("stall_dm", l, 32'(stall_dm_a[l]), 32'(reset & dm_req & !exp_dm));
                chk("mem_en", l, 32'(mem_en_a[l]), 32'(exp_if | exp_dm));
                chk("mem_we", l, 32'(mem_we_a[l]), 32'(exp_dm & dm_we));
                if (exp_if) chk("mem_addr_if", l, 32'(mem_addr_a[l]), 32'(if_addr));
                if (exp_dm) begin
                    chk("mem_addr_dm", l, 32'(mem_addr_a[l]), 32'(dm_addr));
                    chk("mem_funct3", l, 32'(mem_funct3_a[l]), 32'(dm_funct3));
                end
                if (exp_dm && dm_we) chk("mem_wdata", l, mem_wdata_a[l], dm_wdata);
                // A read returns l cycles after grant unless reset was seen in between.
                e_own = 0;
                if (cyc >= l) begin
                    e_own = own_h[cyc-l];
                    for (int j = cyc - l; j <= cyc; j++) if (!rst_h[j]) e_own = 0;
                end
                chk("if_rvalid", l, 32'(if_rvalid_a[l]), 32'(e_own == 1));
                chk("dm_rvalid", l, 32'(dm_rvalid_a[l]), 32'(e_own == 2));
                if (e_own == 1) chk("if_rdata", l, if_rdata_a[l], dat_h[cyc-l]);
                if (e_own == 2) chk("dm_rdata", l, dm_rdata_a[l], dat_h[cyc-l]);
            end
            if (!reset || !if_req || exp_if) deny = 0;
            else if (deny < SM) deny++;
            if (cyc < 1023) cyc++;
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    endtask

    initial begin
        logic [7:0] gnt_pat, stall_pat;
        reset = 1'b0; mem_init = 1'b1;
        if_req = 1'b1; if_addr = 9'h00C;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h030; dm_wdata = 32'h0; dm_funct3 = 3'b010;

        // Reset held with both requests active
        for (int i = 0; i < 3; i++) begin
            step();
            mem_init = 1'b0;
            #2;
            chk("rst_if_gnt", 1, 32'(if_gnt_a[1]), 32'd0);
            chk("rst_dm_gnt", 1, 32'(dm_gnt_a[1]), 32'd0);
            chk("rst_mem_en", 1, 32'(mem_en_a[1]), 32'd0);
            chk("rst_rvalid", 1, 32'({if_rvalid_a[1], dm_rvalid_a[1]}), 32'd0);
        end
        reset = 1'b1;
        #1;
        chk("release_dm_gnt", 1, 32'(dm_gnt_a[1]), 32'd1);
        chk("release_if_gnt", 1, 32'(if_gnt_a[1]), 32'd0);
        step(); idle();

        // IF-only fetches at 0,4,8
        step(); if_req = 1'b1; if_addr = 9'h000; #2;
        chk("fetch0_gnt", 1, 32'(if_gnt_a[1]), 32'd1);
        step(); if_addr = 9'h004; #2;
        chk("fetch0_rvalid", 1, 32'(if_rvalid_a[1]), 32'd1);
        chk("fetch0_rdata", 1, if_rdata_a[1], 32'hA500_0000);
        step(); if_addr = 9'h008; #2;
        chk("fetch4_rdata", 1, if_rdata_a[1], 32'hA500_0001);
        step(); idle(); #2;
        chk("fetch8_rvalid", 1, 32'(if_rvalid_a[1]), 32'd1);
        chk("fetch8_rdata", 1, if_rdata_a[1], 32'hA500_0002);
        chk("fetch_no_dm_rvalid", 1, 32'(dm_rvalid_a[1]), 32'd0);

        // Both requests held: starvation guard gives DM,DM,DM,IF
        gnt_pat = '0; stall_pat = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            if_req = 1'b1; if_addr = 9'h00C; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h030;
            #2;
            gnt_pat   = {gnt_pat[6:0], if_gnt_a[1]};
            stall_pat = {stall_pat[6:0], stall_if_a[1]};
        end
        chk("starve_if_gnt_pat", 1, 32'(gnt_pat), 32'h11);
        chk("starve_stall_pat", 1, 32'(stall_pat), 32'hEE);

        // Store then load of the same word
        step(); if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 9'h020; dm_wdata = 32'hDEAD_BEEF; #2;
        chk("store_mem_we", 1, 32'(mem_we_a[1]), 32'd1);
        step(); dm_we = 1'b0; #2;
        chk("load_mem_we", 1, 32'(mem_we_a[1]), 32'd0);
        chk("store_no_rvalid", 1, 32'(dm_rvalid_a[1]), 32'd0);
        step(); idle(); #2;
        chk("load_rvalid", 1, 32'(dm_rvalid_a[1]), 32'd1);
        chk("load_rdata", 1, dm_rdata_a[1], 32'hDEAD_BEEF);
        step(); step(); #2;
        chk("load_rvalid", 3, 32'(dm_rvalid_a[3]), 32'd1);
        chk("load_rdata", 3, dm_rdata_a[3], 32'hDEAD_BEEF);

        // Alternating IF / DM reads, checked on the RD_LAT=3 instance
        step(); idle(); if_req = 1'b1; if_addr = 9'h010;
        step(); idle(); dm_req = 1'b1; dm_addr = 9'h040;
        step(); idle(); if_req = 1'b1; if_addr = 9'h014;
        step(); idle(); dm_req = 1'b1; dm_addr = 9'h044; #2;
        chk("alt_if_rvalid", 3, 32'(if_rvalid_a[3]), 32'd1);
        chk("alt_if_rdata", 3, if_rdata_a[3], 32'hA500_0004);
        step(); idle(); #2;
        chk("alt_dm_rvalid", 3, 32'(dm_rvalid_a[3]), 32'd1);
        chk("alt_dm_rdata", 3, dm_rdata_a[3], 32'hA500_0010);
        chk("alt_if_quiet", 3, 32'(if_rvalid_a[3]), 32'd0);
        step(); #2;
        chk("alt_if_rdata2", 3, if_rdata_a[3], 32'hA500_0005);
        step(); #2;
        chk("alt_dm_rdata2", 3, dm_rdata_a[3], 32'hA500_0011);

        // Reset pulse one cycle after two granted reads
        step(); idle(); if_req = 1'b1; if_addr = 9'h000;
        step(); idle(); dm_req = 1'b1; dm_addr = 9'h004;
        step(); idle(); reset = 1'b0; #2;
        chk("flush_if_rvalid", 2, 32'(if_rvalid_a[2]), 32'd0);
        step(); reset = 1'b1; #2;
        chk("flush_dm_rvalid", 2, 32'(dm_rvalid_a[2]), 32'd0);
        chk("flush_if_rvalid3", 3, 32'(if_rvalid_a[3]), 32'd0);
        step(); #2;
        chk("flush_quiet", 3, 32'({if_rvalid_a[3], dm_rvalid_a[3], if_rvalid_a[2], dm_rvalid_a[2]}), 32'd0);
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
